// File: rtl/mem_access_unit.sv
// Load/store unit between the core datapath and a valid/ready memory bus.
// Define MAU_MISALIGN_CHECK_EN to reject misaligned halfword/word accesses.
module mem_access_unit #(
  parameter int unsigned TIMEOUT = 64
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req,
  input  logic        we,
  input  logic [2:0]  funct3,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        stall,
  output logic        bus_err,
  output logic        misalign,
  output logic        mem_valid,
  input  logic        mem_ready,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_wstrb,
  input  logic [31:0] mem_rdata
);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

  state_t      state, state_nxt;
  logic [2:0]  f3_q;
  logic [1:0]  off_q;
  logic [7:0]  cnt;
  logic [3:0]  strb_c;
  logic [31:0] wdata_c;
  logic [31:0] load_c;
  logic [7:0]  byte_sel;
  logic [15:0] half_sel;
  logic        misalign_c;
  logic        timeout_c;

`ifdef MAU_MISALIGN_CHECK_EN
  assign misalign_c = (funct3[1:0] == 2'b01 && addr[0]) ||
                      (funct3[1] && addr[1:0] != 2'b00);
`else
  assign misalign_c = 1'b0;
`endif

  // Last idle BUSY cycle: the counter would reach TIMEOUT at this edge.
  assign timeout_c = (cnt == CNT_LAST);

  always_comb begin
    // NOTE: every always_comb output gets a default first so no latch is inferred.
    strb_c  = 4'b1111;
    wdata_c = wdata;
    case (funct3[1:0])
      2'b00: begin
        strb_c  = 4'b0001 << addr[1:0];
        wdata_c = {4{wdata[7:0]}};
      end
      2'b01: begin
        strb_c  = addr[1] ? 4'b1100 : 4'b0011;
        wdata_c = {2{wdata[15:0]}};
      end
      default: ;
    endcase
    if (!we) strb_c = 4'b0000;
  end

  always_comb begin
    case (off_q)
      2'd1:    byte_sel = mem_rdata[15:8];
      2'd2:    byte_sel = mem_rdata[23:16];
      2'd3:    byte_sel = mem_rdata[31:24];
      default: byte_sel = mem_rdata[7:0];
    endcase
    half_sel = off_q[1] ? mem_rdata[31:16] : mem_rdata[15:0];
    case (f3_q[1:0])
      2'b00:   load_c = f3_q[2] ? {24'b0, byte_sel} : {{24{byte_sel[7]}}, byte_sel};
      2'b01:   load_c = f3_q[2] ? {16'b0, half_sel} : {{16{half_sel[15]}}, half_sel};
      default: load_c = mem_rdata;
    endcase
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (req) state_nxt = misalign_c ? DONE : BUSY;
      BUSY:    if (mem_ready || timeout_c) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    if (rst) begin
      state     <= IDLE;
      mem_we    <= 1'b0;
      mem_addr  <= 32'h0;
      mem_wdata <= 32'h0;
      mem_wstrb <= 4'b0000;
      f3_q      <= 3'b000;
      off_q     <= 2'b00;
      cnt       <= 8'h0;
      rdata     <= 32'h0;
      bus_err   <= 1'b0;
      misalign  <= 1'b0;
    end else begin
      state    <= state_nxt;
      bus_err  <= 1'b0;
      misalign <= 1'b0;
      case (state)
        IDLE: begin
          if (req && misalign_c) begin
            misalign <= 1'b1;
            rdata    <= 32'h0;
          end else if (req) begin
            mem_addr  <= {addr[31:2], 2'b00};
            mem_we    <= we;
            mem_wstrb <= strb_c;
            mem_wdata <= wdata_c;
            f3_q      <= funct3;
            off_q     <= addr[1:0];
            cnt       <= 8'h0;
          end
        end
        BUSY: begin
          if (mem_ready) begin
            rdata <= mem_we ? 32'h0 : load_c;
          end else if (timeout_c) begin
            bus_err <= 1'b1;
            rdata   <= 32'h0;
          end else begin
            cnt <= cnt + 8'd1;
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    mem_valid = (state == BUSY);
    stall     = req && (state != DONE) && !rst;
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// Self-checking bench for mem_access_unit: directed vector table, reset
// corner cases and randomized accesses checked against a transaction model.
module tb_mem_access_unit;

  localparam int TO    = 4;
  localparam int NEVER = 255;

  logic        clk = 1'b0;
  logic        rst, req, we;
  logic [2:0]  funct3;
  logic [31:0] addr, wdata, rdata;
  logic        stall, bus_err, misalign;
  logic        mem_valid, mem_ready, mem_we;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic [3:0]  mem_wstrb;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic        we;
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [31:0] wdata;
    int          lat;
    logic [31:0] mrd;
    logic [31:0] exp_rdata;
    logic [31:0] exp_addr;
    logic [3:0]  exp_strb;
    logic [31:0] exp_wdata;
    int          exp_valid;
    int          exp_stall;
    logic        exp_berr;
    logic        exp_mis;
  } txn_t;

  txn_t vt[11];

  mem_access_unit #(.TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst), .req(req), .we(we), .funct3(funct3),
    .addr(addr), .wdata(wdata), .rdata(rdata), .stall(stall),
    .bus_err(bus_err), .misalign(misalign), .mem_valid(mem_valid),
    .mem_ready(mem_ready), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Expected outcome of one access, derived from access size and byte address.
  function automatic txn_t model(input txn_t t);
    txn_t r = t;
    int size = (t.f3[1:0] == 2'b00) ? 1 : (t.f3[1:0] == 2'b01) ? 2 : 4;
    int low  = int'(t.addr[1:0]);
    int off  = low - (low % size);
    logic [31:0] v;
`ifdef MAU_MISALIGN_CHECK_EN
    r.exp_mis = (low % size) != 0;
`else
    r.exp_mis = 1'b0;
`endif
    r.exp_berr  = 1'b0;
    r.exp_addr  = t.addr - 32'(low);
    r.exp_strb  = t.we ? 4'(((1 << size) - 1) << off) : 4'b0000;
    for (int i = 0; i < 4; i++) r.exp_wdata[8*i +: 8] = t.wdata[8*(i % size) +: 8];
    if (r.exp_mis) begin
      r.exp_valid = 0;
      r.exp_rdata = 32'h0;
    end else if (t.lat >= TO) begin
      r.exp_valid = TO;
      r.exp_berr  = 1'b1;
      r.exp_rdata = 32'h0;
    end else begin
      r.exp_valid = t.lat + 1;
      v = t.mrd >> (8 * off);
      if (size == 1) v = t.f3[2] ? (v & 32'hFF)   : 32'($signed(v[7:0]));
      if (size == 2) v = t.f3[2] ? (v & 32'hFFFF) : 32'($signed(v[15:0]));
      r.exp_rdata = t.we ? 32'h0 : v;
    end
    r.exp_stall = r.exp_valid + 1;
    return r;
  endfunction

  // Drives one access with req held until DONE; addr/wdata are scrambled while busy.
  task automatic run_txn(input string tag, input txn_t t);
    int nvalid = 0, nstall = 0, cyc = 0;
    bit done = 0, unstable = 0;
    logic [31:0] a0 = 0, w0 = 0, rd = 0;
    logic [3:0]  s0 = 0;
    logic        we0 = 0, be = 0, mi = 0;
    @(negedge clk);
    req = 1'b1; we = t.we; funct3 = t.f3; addr = t.addr; wdata = t.wdata;
    mem_rdata = t.mrd; mem_ready = 1'b0;
    while (!done && cyc < 20) begin
      #1;
      if (stall) nstall++;
      if (mem_valid) begin
        if (nvalid == 0) begin
          a0 = mem_addr; w0 = mem_wdata; s0 = mem_wstrb; we0 = mem_we;
        end else if (a0 !== mem_addr || w0 !== mem_wdata || s0 !== mem_wstrb || we0 !== mem_we) begin
          unstable = 1;
        end
        mem_ready = (nvalid == t.lat);
        nvalid++;
      end else begin
        mem_ready = 1'b0;
      end
      if (!stall) begin
        done = 1; rd = rdata; be = bus_err; mi = misalign;
      end
      @(negedge clk);
      cyc++;
      if (!done) begin
        addr = $urandom; wdata = $urandom;
      end
    end
    check({tag, " done reached"}, 32'(done), 32'd1);
    check({tag, " stall cycles"}, 32'(nstall), 32'(t.exp_stall));
    check({tag, " valid cycles"}, 32'(nvalid), 32'(t.exp_valid));
    check({tag, " rdata"}, rd, t.exp_rdata);
    check({tag, " bus_err"}, 32'(be), 32'(t.exp_berr));
    check({tag, " misalign"}, 32'(mi), 32'(t.exp_mis));
    if (nvalid > 0) begin
      check({tag, " mem_addr"}, a0, t.exp_addr);
      check({tag, " mem_we"}, 32'(we0), 32'(t.we));
      check({tag, " mem_wstrb"}, 32'(s0), 32'(t.exp_strb));
      check({tag, " bus stable"}, 32'(unstable), 32'd0);
      if (t.we) check({tag, " mem_wdata"}, w0, t.exp_wdata);
    end
    req = 1'b0; mem_ready = 1'b0;
    #1;
    check({tag, " idle valid"}, 32'(mem_valid), 32'd0);
    check({tag, " idle pulses"}, {30'd0, bus_err, misalign}, 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    txn_t t;
    vt[0] = '{1'b0, 3'b010, 32'h104, 32'h0,        0,     32'hDEADBEEF, 32'hDEADBEEF, 32'h104, 4'b0000, 32'h0,        1, 2, 1'b0, 1'b0};
    vt[1] = '{1'b0, 3'b000, 32'h103, 32'h0,        0,     32'h80FF0011, 32'hFFFFFF80, 32'h100, 4'b0000, 32'h0,        1, 2, 1'b0, 1'b0};
    vt[2] = '{1'b0, 3'b100, 32'h103, 32'h0,        1,     32'h80FF0011, 32'h00000080, 32'h100, 4'b0000, 32'h0,        2, 3, 1'b0, 1'b0};
    vt[3] = '{1'b0, 3'b101, 32'h102, 32'h0,        0,     32'h80FF0011, 32'h000080FF, 32'h100, 4'b0000, 32'h0,        1, 2, 1'b0, 1'b0};
    vt[4] = '{1'b0, 3'b001, 32'h102, 32'h0,        2,     32'h80FF0011, 32'hFFFF80FF, 32'h100, 4'b0000, 32'h0,        3, 4, 1'b0, 1'b0};
    vt[5] = '{1'b0, 3'b010, 32'h200, 32'h0,        NEVER, 32'h55555555, 32'h0,        32'h200, 4'b0000, 32'h0,        4, 5, 1'b1, 1'b0};
    vt[6] = '{1'b0, 3'b010, 32'h204, 32'h0,        3,     32'h12345678, 32'h12345678, 32'h204, 4'b0000, 32'h0,        4, 5, 1'b0, 1'b0};
    vt[7] = '{1'b1, 3'b000, 32'h021, 32'h000000A5, 0,     32'hFFFFFFFF, 32'h0,        32'h020, 4'b0010, 32'hA5A5A5A5, 1, 2, 1'b0, 1'b0};
    vt[8] = '{1'b1, 3'b001, 32'h022, 32'h1234BEEF, 1,     32'hFFFFFFFF, 32'h0,        32'h020, 4'b1100, 32'hBEEFBEEF, 2, 3, 1'b0, 1'b0};
    vt[9] = '{1'b0, 3'b110, 32'h108, 32'h0,        0,     32'hA1B2C3D4, 32'hA1B2C3D4, 32'h108, 4'b0000, 32'h0,        1, 2, 1'b0, 1'b0};
`ifdef MAU_MISALIGN_CHECK_EN
    vt[10] = '{1'b1, 3'b010, 32'h102, 32'hCAFEF00D, 0,    32'h0,        32'h0,        32'h0,   4'b0000, 32'h0,        0, 1, 1'b0, 1'b1};
`else
    vt[10] = '{1'b1, 3'b010, 32'h102, 32'hCAFEF00D, 0,    32'h0,        32'h0,        32'h100, 4'b1111, 32'hCAFEF00D, 1, 2, 1'b0, 1'b0};
`endif

    rst = 1'b1; req = 1'b1; we = 1'b1; funct3 = 3'b010; addr = 32'h0;
    wdata = 32'h0; mem_ready = 1'b1; mem_rdata = 32'h0;
    repeat (2) @(negedge clk);
    #1;
    check("reset stall", 32'(stall), 32'd0);
    check("reset mem_valid", 32'(mem_valid), 32'd0);
    check("reset mem_we", 32'(mem_we), 32'd0);
    check("reset mem_wstrb", 32'(mem_wstrb), 32'd0);
    check("reset mem_addr", mem_addr, 32'h0);
    check("reset mem_wdata", mem_wdata, 32'h0);
    check("reset rdata", rdata, 32'h0);
    check("reset pulses", {30'd0, bus_err, misalign}, 32'd0);
    @(negedge clk);
    rst = 1'b0; req = 1'b0; mem_ready = 1'b0;

    for (int i = 0; i < 11; i++) run_txn($sformatf("vec%0d", i), vt[i]);

    // Reset in the second BUSY cycle while the bus answers: access is discarded.
    run_txn("preload", vt[9]);
    @(negedge clk);
    req = 1'b1; we = 1'b0; funct3 = 3'b010; addr = 32'h300; mem_ready = 1'b0;
    @(negedge clk);
    #1 check("rstbusy busy1 valid", 32'(mem_valid), 32'd1);
    @(negedge clk);
    rst = 1'b1; mem_ready = 1'b1; mem_rdata = 32'h77777777;
    #1 check("rstbusy stall in rst", 32'(stall), 32'd0);
    @(negedge clk);
    rst = 1'b0; mem_ready = 1'b0;
    #1;
    check("rstbusy valid", 32'(mem_valid), 32'd0);
    check("rstbusy rdata", rdata, 32'h0);
    check("rstbusy bus_err", 32'(bus_err), 32'd0);
    check("rstbusy idle stall", 32'(stall), 32'd1);
    @(negedge clk);
    #1 check("rstbusy restart valid", 32'(mem_valid), 32'd1);
    req = 1'b0; rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 40; i++) begin
      t = vt[0];
      t.we    = 1'($urandom_range(0, 1));
      t.f3    = 3'($urandom_range(0, 7));
      t.addr  = $urandom & 32'h3FF;
      t.wdata = $urandom;
      t.mrd   = $urandom;
      t.lat   = int'($urandom_range(0, 5));
      run_txn($sformatf("rand%0d", i), model(t));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
